// File: rtl/conv_layer_output_writer.sv
// Writes finished convolution feature rows into external RAM one word per beat.
// Optional build macro CONV_OUT_RELU_EN clamps negative words to zero at the output mux.
//   state | meaning
//   IDLE  | active slot empty, no write in flight
//   WRITE | active slot valid, ext_ram_we asserted
module conv_layer_output_writer #(
  parameter int ARRAY_SIZE     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int EXT_ADDR_WIDTH = 10,
  parameter int FEATURE_NUM    = 4,
  parameter int FEATURE_ROWS   = 6,
  parameter int BASE_ADDR      = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             kernel_calc_fin,
  input  logic [1:0]                       feature_idx,
  input  logic [2:0]                       feature_row,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature_output,
  output logic [EXT_ADDR_WIDTH-1:0]        ext_ram_addr,
  output logic [DATA_WIDTH-1:0]            ext_ram_data,
  output logic                             ext_ram_we,
  input  logic                             ext_ram_ready,
  output logic                             busy,
  output logic                             overflow,
  output logic                             layer_done
);

  localparam int ROW_W      = ARRAY_SIZE * DATA_WIDTH;
  localparam int COL_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int TOTAL_ROWS = FEATURE_NUM * FEATURE_ROWS;
  localparam int RCNT_W     = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1;

  typedef enum logic {IDLE, WRITE} state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   act_data_q, act_data_d;
  logic [1:0]         act_idx_q, act_idx_d;
  logic [2:0]         act_row_q, act_row_d;
  logic               pend_vld_q, pend_vld_d;
  logic [ROW_W-1:0]   pend_data_q, pend_data_d;
  logic [1:0]         pend_idx_q, pend_idx_d;
  logic [2:0]         pend_row_q, pend_row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [RCNT_W-1:0]  row_cnt_q, row_cnt_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic               layer_done_q, layer_done_d;

  logic               cap, beat, last_beat, to_act, to_pend;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    cap       = enable & kernel_calc_fin;
    beat      = (state_q == WRITE) & ext_ram_ready;
    last_beat = beat & (col_q == COL_W'(ARRAY_SIZE - 1));
    // A slot counts as free if it is vacated on this same edge.
    to_act    = cap & ((state_q == IDLE) | (last_beat & ~pend_vld_q));
    to_pend   = cap & ~to_act & (~pend_vld_q | last_beat);

    state_d      = state_q;
    act_data_d   = act_data_q;
    act_idx_d    = act_idx_q;
    act_row_d    = act_row_q;
    pend_vld_d   = pend_vld_q;
    pend_data_d  = pend_data_q;
    pend_idx_d   = pend_idx_q;
    pend_row_d   = pend_row_q;
    col_d        = col_q;
    row_cnt_d    = row_cnt_q;
    overflow_d   = overflow_q | (cap & ~to_act & ~to_pend);
    layer_done_d = 1'b0;

    if (beat) begin
      col_d = last_beat ? '0 : col_q + 1'b1;
    end

    if (last_beat) begin
      if (row_cnt_q == RCNT_W'(TOTAL_ROWS - 1)) begin
        row_cnt_d    = '0;
        layer_done_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end

      if (pend_vld_q) begin
        act_data_d = pend_data_q;
        act_idx_d  = pend_idx_q;
        act_row_d  = pend_row_q;
        pend_vld_d = 1'b0;
      end else if (!to_act) begin
        state_d = IDLE;
      end
    end

    if (to_act) begin
      act_data_d = feature_output;
      act_idx_d  = feature_idx;
      act_row_d  = feature_row;
      state_d    = WRITE;
    end

    if (to_pend) begin
      pend_data_d = feature_output;
      pend_idx_d  = feature_idx;
      pend_row_d  = feature_row;
      pend_vld_d  = 1'b1;
    end

    busy_d = (state_d == WRITE) | pend_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      act_data_q   <= '0;
      act_idx_q    <= '0;
      act_row_q    <= '0;
      pend_vld_q   <= 1'b0;
      pend_data_q  <= '0;
      pend_idx_q   <= '0;
      pend_row_q   <= '0;
      col_q        <= '0;
      row_cnt_q    <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_data_q   <= act_data_d;
      act_idx_q    <= act_idx_d;
      act_row_q    <= act_row_d;
      pend_vld_q   <= pend_vld_d;
      pend_data_q  <= pend_data_d;
      pend_idx_q   <= pend_idx_d;
      pend_row_q   <= pend_row_d;
      col_q        <= col_d;
      row_cnt_q    <= row_cnt_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      layer_done_q <= layer_done_d;
    end
  end

  // Column 0 sits in the most significant slice of the row.
  always_comb begin
    word         = act_data_q[(ARRAY_SIZE - 1 - int'(col_q)) * DATA_WIDTH +: DATA_WIDTH];
    ext_ram_we   = (state_q == WRITE);
    ext_ram_addr = '0;
    ext_ram_data = '0;
    if (state_q == WRITE) begin
      ext_ram_addr = EXT_ADDR_WIDTH'(32'(BASE_ADDR)
                     + (32'(act_idx_q) * 32'(FEATURE_ROWS) + 32'(act_row_q)) * 32'(ARRAY_SIZE)
                     + 32'(col_q));
`ifdef CONV_OUT_RELU_EN
      ext_ram_data = word[DATA_WIDTH-1] ? '0 : word;
`else
      ext_ram_data = word;
`endif
    end
  end

  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_conv_layer_output_writer.sv
// Directed bench for conv_layer_output_writer with a row-queue reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_conv_layer_output_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         kernel_calc_fin;
  logic [1:0]   feature_idx;
  logic [2:0]   feature_row;
  logic [191:0] feature_output;
  logic [9:0]   ext_ram_addr;
  logic [31:0]  ext_ram_data;
  logic         ext_ram_we;
  logic         ext_ram_ready;
  logic         busy;
  logic         overflow;
  logic         layer_done;

  always #5 clk = ~clk;

  conv_layer_output_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .kernel_calc_fin(kernel_calc_fin),
    .feature_idx    (feature_idx),
    .feature_row    (feature_row),
    .feature_output (feature_output),
    .ext_ram_addr   (ext_ram_addr),
    .ext_ram_data   (ext_ram_data),
    .ext_ram_we     (ext_ram_we),
    .ext_ram_ready  (ext_ram_ready),
    .busy           (busy),
    .overflow       (overflow),
    .layer_done     (layer_done)
  );

  typedef struct packed {
    logic [1:0]       idx;
    logic [2:0]       row;
    logic [5:0][31:0] w;   // w[c] is column c
  } row_t;

  row_t             mq[$];
  int               mcol;
  bit               movf;
  int               mrows;
  bit               mld;
  bit               chk_en = 1'b0;
  logic [5:0][31:0] cur_w;
  logic [1:0]       cur_idx;
  logic [2:0]       cur_row;
  int               n_cmp = 0;
  int               n_err = 0;
  int               ld_cnt = 0;

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef CONV_OUT_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [9:0] exp_addr(input row_t r, input int c);
    int a;
    a = (int'(r.idx) * 6 + int'(r.row)) * 6 + c;
    return a[9:0];
  endfunction

  function automatic logic [5:0][31:0] mk(input logic [31:0] a, b, c, d, e, f);
    logic [5:0][31:0] w;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e; w[5] = f;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two outstanding rows, drained in order.
  always @(posedge clk) begin : model
    bit ldn;
    ldn = 1'b0;
    if (!rst_n) begin
      mq.delete();
      mcol  = 0;
      movf  = 1'b0;
      mrows = 0;
    end else begin
      if (mq.size() > 0 && ext_ram_ready) begin
        if (mcol == 5) begin
          void'(mq.pop_front());
          mcol = 0;
          mrows++;
          if (mrows == 24) begin
            mrows = 0;
            ldn   = 1'b1;
          end
        end else begin
          mcol++;
        end
      end
      if (enable && kernel_calc_fin) begin
        if (mq.size() < 2) mq.push_back('{idx: cur_idx, row: cur_row, w: cur_w});
        else movf = 1'b1;
      end
    end
    mld = ldn;
  end

  always @(negedge clk) begin
    if (layer_done) ld_cnt++;
    if (chk_en) begin
      check("we", 64'(ext_ram_we), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("addr", 64'(ext_ram_addr), 64'(exp_addr(mq[0], mcol)));
        check("data", 64'(ext_ram_data), 64'(relu(mq[0].w[mcol])));
      end
      check("busy", 64'(busy), 64'(mq.size() > 0));
      check("overflow", 64'(overflow), 64'(movf));
      check("layer_done", 64'(layer_done), 64'(mld));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [1:0] i, input logic [2:0] r, input logic [5:0][31:0] w);
    cur_w       = w;
    cur_idx     = i;
    cur_row     = r;
    feature_idx = i;
    feature_row = r;
    for (int c = 0; c < 6; c++) feature_output[(5 - c) * 32 +: 32] = w[c];
    kernel_calc_fin = 1'b1;
    step();
    kernel_calc_fin = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  logic [5:0][31:0] w1;
  int               ld_base;

  initial begin
    rst_n           = 1'b0;
    enable          = 1'b1;
    kernel_calc_fin = 1'b0;
    feature_idx     = '0;
    feature_row     = '0;
    feature_output  = '0;
    ext_ram_ready   = 1'b1;
    cur_w           = '0;
    cur_idx         = '0;
    cur_row         = '0;
    w1 = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000);

    step();
    chk_en = 1'b1;
    step();
    check("rst_we", 64'(ext_ram_we), 64'(0));
    check("rst_addr", 64'(ext_ram_addr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    step();

    // Basic row, ready held high.
    capture(2'd1, 3'd2, w1);
    check("t1_we", 64'(ext_ram_we), 64'(1));
    check("t1_addr0", 64'(ext_ram_addr), 64'(48));
    check("t1_data0", 64'(ext_ram_data), 64'(32'h3F800000));
    check("t1_busy", 64'(busy), 64'(1));
    step(); step(); step(); step(); step();
    check("t1_addr5", 64'(ext_ram_addr), 64'(53));
    check("t1_data5", 64'(ext_ram_data), 64'(32'h40C00000));
    step();
    check("t1_we_after", 64'(ext_ram_we), 64'(0));
    check("t1_busy_after", 64'(busy), 64'(0));

    // Back-pressure during column 2.
    capture(2'd1, 3'd2, w1);
    step(); step();
    ext_ram_ready = 1'b0;
    step(); step(); step();
    check("t2_hold_addr", 64'(ext_ram_addr), 64'(50));
    check("t2_hold_data", 64'(ext_ram_data), 64'(32'h40400000));
    check("t2_hold_we", 64'(ext_ram_we), 64'(1));
    ext_ram_ready = 1'b1;
    step();
    check("t2_col3_addr", 64'(ext_ram_addr), 64'(51));
    wait_idle();

    // Three captures while stalled: third is dropped.
    ext_ram_ready = 1'b0;
    capture(2'd0, 3'd1, mk(1, 2, 3, 4, 5, 6));
    step();
    capture(2'd2, 3'd4, mk(7, 8, 9, 10, 11, 12));
    step();
    capture(2'd3, 3'd3, mk(13, 14, 15, 16, 17, 18));
    check("t3_ovf", 64'(overflow), 64'(1));
    ext_ram_ready = 1'b1;
    wait_idle();
    check("t3_ovf_sticky", 64'(overflow), 64'(1));

    // Capture on the last beat with pending empty: no bubble.
    capture(2'd0, 3'd5, mk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5));
    step(); step(); step(); step(); step();
    capture(2'd2, 3'd1, mk(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5));
    check("t4_we", 64'(ext_ram_we), 64'(1));
    check("t4_addr", 64'(ext_ram_addr), 64'(78));
    check("t4_data", 64'(ext_ram_data), 64'(32'hB0));
    wait_idle();

    // Reset in the middle of a row abandons it.
    capture(2'd0, 3'd0, w1);
    step(); step();
    rst_n = 1'b0;
    step();
    check("t6_rst_we", 64'(ext_ram_we), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_ovf", 64'(overflow), 64'(0));
    rst_n = 1'b1;
    step(); step();
    check("t6_post_we", 64'(ext_ram_we), 64'(0));

    // Full layer of 24 rows, back to back.
    ld_base = ld_cnt;
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 6; r++) begin
        capture(2'(i), 3'(r), mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
        if (i == 3 && r == 5) begin
          step(); step(); step(); step(); step();
          check("t5_addr_last", 64'(ext_ram_addr), 64'(143));
          step();
          check("t5_ld_pulse", 64'(layer_done), 64'(1));
        end else begin
          step(); step(); step(); step(); step();
        end
      end
    end
    wait_idle();
    step();
    check("t5_ld_once", 64'(ld_cnt - ld_base), 64'(1));

    // Row counter wrapped: one more row must not pulse layer_done.
    capture(2'd0, 3'd0, w1);
    wait_idle();
    step();
    check("t5_wrap", 64'(ld_cnt - ld_base), 64'(1));

    // ReLU pattern row.
    capture(2'd3, 3'd0, mk(32'hBF800000, 32'h3F800000, 32'h80000000, 32'h0, 32'hC0000000, 32'h40000000));
    check("t7_addr0", 64'(ext_ram_addr), 64'(108));
`ifdef CONV_OUT_RELU_EN
    check("t7_data0", 64'(ext_ram_data), 64'(32'h0));
`else
    check("t7_data0", 64'(ext_ram_data), 64'(32'hBF800000));
`endif
    step();
    check("t7_data1", 64'(ext_ram_data), 64'(32'h3F800000));
    step();
`ifdef CONV_OUT_RELU_EN
    check("t7_data2", 64'(ext_ram_data), 64'(32'h0));
`else
    check("t7_data2", 64'(ext_ram_data), 64'(32'h80000000));
`endif
    wait_idle();

    // Enable low: capture ignored, no overflow.
    enable = 1'b0;
    capture(2'd1, 3'd1, w1);
    check("t8_ignored_we", 64'(ext_ram_we), 64'(0));
    check("t8_ignored_ovf", 64'(overflow), 64'(0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
